// File: rtl/minterm_scanner_if.sv
// Minterm stream bundle: the scanner drives valid/index, the consumer drives ready.
interface minterm_scanner_if;
  logic       m_valid;
  logic [3:0] m_index;
  logic       m_ready;

  modport master (output m_valid, output m_index, input m_ready);
  modport slave  (input m_valid, input m_index, output m_ready);
endinterface

// File: rtl/minterm_scanner.sv
// Truth-table reader for a 4-input function: scans idx 0..15, builds the minterm mask, then streams set indices.
// Optional reference-mask comparison is built only when MINTERM_CHECK_EN is defined.
module minterm_scanner #(
  parameter int SETTLE = 0
`ifdef MINTERM_CHECK_EN
  , parameter logic [15:0] EXPECTED = 16'h08AE
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        x,
  output logic        y,
  output logic        w,
  output logic        z,
  input  logic        s_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] mask,
  output logic [4:0]  count,
  output logic        mismatch,
  minterm_scanner_if.master m
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_t      state_r, state_s;
  logic [3:0]  idx_r, idx_s;
  logic [3:0]  settle_r, settle_s;
  logic [3:0]  ptr_r, ptr_s;
  logic [15:0] mask_r, mask_s;
  logic [4:0]  count_r, count_s;
  logic        m_valid_r, m_valid_s;
  logic [3:0]  m_index_r, m_index_s;
  logic        busy_r, done_r;

  // Next-state and next-value logic for the scan/emit sequencer
  always_comb begin
    state_s  = state_r;
    idx_s    = idx_r;
    settle_s = settle_r;
    ptr_s    = ptr_r;
    mask_s   = mask_r;
    count_s  = count_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s  = SCAN;
          idx_s    = 4'd0;
          settle_s = 4'd0;
          ptr_s    = 4'd0;
          mask_s   = 16'h0000;
          count_s  = 5'd0;
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        if (settle_r == SETTLE_C) begin
          settle_s       = 4'd0;
          mask_s[idx_r]  = s_in;
          count_s        = count_r + {4'd0, s_in};
          if (idx_r == 4'd15) begin
            idx_s   = 4'd0;
            ptr_s   = 4'd0;
            state_s = EMIT;
          end else begin
            idx_s = idx_r + 4'd1;
          end
        end else begin
          settle_s = settle_r + 4'd1;
        end
      end
      EMIT: begin
        // m_valid_r always mirrors mask_r[ptr_r] here, so empty cells advance unconditionally
        if (!m_valid_r || m.m_ready) begin
          if (ptr_r == 4'd15) begin
            ptr_s   = 4'd0;
            state_s = DONE;
          end else begin
            ptr_s = ptr_r + 4'd1;
          end
        end else begin
          ptr_s = ptr_r;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    m_valid_s = (state_s == EMIT) ? mask_s[ptr_s] : 1'b0;
    m_index_s = (state_s == EMIT) ? ptr_s : m_index_r;
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      idx_r     <= 4'd0;
      settle_r  <= 4'd0;
      ptr_r     <= 4'd0;
      mask_r    <= 16'h0000;
      count_r   <= 5'd0;
      m_valid_r <= 1'b0;
      m_index_r <= 4'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      idx_r     <= idx_s;
      settle_r  <= settle_s;
      ptr_r     <= ptr_s;
      mask_r    <= mask_s;
      count_r   <= count_s;
      m_valid_r <= m_valid_s;
      m_index_r <= m_index_s;
      busy_r    <= (state_s == SCAN) || (state_s == EMIT);
      done_r    <= (state_s == DONE);
    end
  end

`ifdef MINTERM_CHECK_EN
  logic mismatch_r;

  // Reference comparison latched as DONE completes, cleared by the next start
  always_ff @(posedge clk) begin
    if (reset) begin
      mismatch_r <= 1'b0;
    end else if ((state_r == IDLE) && start) begin
      mismatch_r <= 1'b0;
    end else if (state_r == DONE) begin
      mismatch_r <= (mask_r != EXPECTED);
    end else begin
      mismatch_r <= mismatch_r;
    end
  end

  assign mismatch = mismatch_r;
`else
  assign mismatch = 1'b0;
`endif

  // idx_r is forced to 0 outside SCAN, so the stimulus is already zero there
  assign x         = idx_r[3];
  assign y         = idx_r[2];
  assign w         = idx_r[1];
  assign z         = idx_r[0];
  assign busy      = busy_r;
  assign done      = done_r;
  assign mask      = mask_r;
  assign count     = count_r;
  assign m.m_valid = m_valid_r;
  assign m.m_index = m_index_r;

endmodule

// File: tb/tb_minterm_scanner.sv
// Directed bench for minterm_scanner: DUT a with SETTLE=0, DUT b with SETTLE=3, both reading the same function table.
module tb_minterm_scanner;

  localparam logic [15:0] SOP6 = 16'h08AE;  // SoP(1,2,3,5,7,11)
  localparam logic [15:0] SOP5 = 16'h00AE;  // SoP(1,2,3,5,7)
`ifdef MINTERM_CHECK_EN
  localparam logic MM_SOP5 = 1'b1;
`else
  localparam logic MM_SOP5 = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start_a, start_b, m_ready, sel;
  logic [15:0] fn_mask;
  logic        x_a, y_a, w_a, z_a, s_a, busy_a, done_a, mm_a;
  logic        x_b, y_b, w_b, z_b, s_b, busy_b, done_b, mm_b;
  logic [15:0] mask_a, mask_b;
  logic [4:0]  count_a, count_b;

  minterm_scanner_if if_a ();
  minterm_scanner_if if_b ();
  assign if_a.m_ready = m_ready;
  assign if_b.m_ready = m_ready;

  assign s_a = fn_mask[{x_a, y_a, w_a, z_a}];
  assign s_b = fn_mask[{x_b, y_b, w_b, z_b}];

  minterm_scanner #(.SETTLE(0)) dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .x(x_a), .y(y_a), .w(w_a), .z(z_a), .s_in(s_a),
    .busy(busy_a), .done(done_a), .mask(mask_a), .count(count_a),
    .mismatch(mm_a), .m(if_a)
  );

  minterm_scanner #(.SETTLE(3)) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .x(x_b), .y(y_b), .w(w_b), .z(z_b), .s_in(s_b),
    .busy(busy_b), .done(done_b), .mask(mask_b), .count(count_b),
    .mismatch(mm_b), .m(if_b)
  );

  // Observation view of whichever DUT is under test
  logic [3:0]  o_idx, o_index;
  logic        o_busy, o_done, o_valid, o_mm;
  logic [15:0] o_mask;
  logic [4:0]  o_count;
  assign o_idx   = sel ? {x_b, y_b, w_b, z_b} : {x_a, y_a, w_a, z_a};
  assign o_busy  = sel ? busy_b : busy_a;
  assign o_done  = sel ? done_b : done_a;
  assign o_valid = sel ? if_b.m_valid : if_a.m_valid;
  assign o_index = sel ? if_b.m_index : if_a.m_index;
  assign o_mm    = sel ? mm_b : mm_a;
  assign o_mask  = sel ? mask_b : mask_a;
  assign o_count = sel ? count_b : count_a;

  int checks = 0;
  int errors = 0;
  int done_at, busy_cnt, stim_err, stall_err, valid_cnt;
  int beats[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_mask"}, {16'd0, o_mask}, 32'd0);
    check({tag, "_count"}, {27'd0, o_count}, 32'd0);
    check({tag, "_ctl"}, {28'd0, o_busy, o_done, o_valid, o_mm}, 32'd0);
    check({tag, "_idx_index"}, {24'd0, o_idx, o_index}, 32'd0);
  endtask

  // Expected beats are the set bits of a hand-written mask, ascending
  task automatic check_beats(input string tag, input logic [15:0] exp_mask);
    int k;
    int n_exp;
    n_exp = 0;
    for (int i = 0; i < 16; i++) if (exp_mask[i]) n_exp++;
    check({tag, "_nbeats"}, beats.size(), n_exp);
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (exp_mask[i]) begin
        if (k < beats.size()) check({tag, "_beat"}, beats[k], i);
        k++;
      end
    end
  endtask

  // Pulse start, then run until done with a bounded cycle budget
  task automatic run(input int settle, input int ready_mode, input int start_at);
    int n;
    int exp_idx;
    logic prev_stall;
    logic [3:0] prev_index;
    beats.delete();
    done_at = 0; busy_cnt = 0; stim_err = 0; stall_err = 0; valid_cnt = 0;
    prev_stall = 1'b0;
    prev_index = 4'd0;
    set_start(1'b1);
    tick();
    set_start(1'b0);
    n = 1;
    while ((n < 400) && (done_at == 0)) begin
      if (o_done) begin
        done_at = n;
      end else begin
        if (o_busy) busy_cnt++;
        if (o_valid) valid_cnt++;
        exp_idx = (n <= 16 * (settle + 1)) ? (n - 1) / (settle + 1) : 0;
        if (int'(o_idx) != exp_idx) stim_err++;
        if (prev_stall && !(o_valid && (o_index == prev_index))) stall_err++;
        m_ready = (ready_mode == 0) ? 1'b1 : ((n % 3) == 1);
        set_start(n == start_at);
        if (o_valid && m_ready) beats.push_back(int'(o_index));
        prev_stall = o_valid && !m_ready;
        prev_index = o_index;
        tick();
        n++;
      end
    end
    m_ready = 1'b1;
    set_start(1'b0);
  endtask

  initial begin
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; m_ready = 1'b1;
    sel = 1'b0; fn_mask = SOP6;
    tick();
    tick();
    reset = 1'b0;
    check_reset_state("reset");

    // SoP, SETTLE=0, always ready
    run(0, 0, 0);
    check("sop_done_at", done_at, 33);
    check("sop_busy_cycles", busy_cnt, 32);
    check("sop_busy_in_done", {31'd0, o_busy}, 32'd0);
    check("sop_stimulus", stim_err, 0);
    check("sop_mask", {16'd0, o_mask}, {16'd0, SOP6});
    check("sop_count", {27'd0, o_count}, 32'd6);
    check_beats("sop", SOP6);
    tick();
    check("sop_done_pulse", {30'd0, o_done, o_busy}, 32'd0);
    check("sop_mismatch", {31'd0, o_mm}, 32'd0);

    // constant 0
    fn_mask = 16'h0000;
    run(0, 0, 0);
    check("zero_done_at", done_at, 33);
    check("zero_mask", {16'd0, o_mask}, 32'd0);
    check("zero_count", {27'd0, o_count}, 32'd0);
    check("zero_valid_cycles", valid_cnt, 0);
    tick();

    // constant 1
    fn_mask = 16'hFFFF;
    run(0, 0, 0);
    check("ones_done_at", done_at, 33);
    check("ones_mask", {16'd0, o_mask}, 32'h0000FFFF);
    check("ones_count", {27'd0, o_count}, 32'd16);
    check_beats("ones", 16'hFFFF);
    tick();

    // SoP with back-pressure 1,0,0,1,...
    fn_mask = SOP6;
    run(0, 1, 0);
    check("stall_finished", {31'd0, done_at != 0}, 32'd1);
    check("stall_hold", stall_err, 0);
    check_beats("stall", SOP6);
    tick();

    // SETTLE=3 on DUT b
    sel = 1'b1;
    run(3, 0, 0);
    check("settle3_done_at", done_at, 81);
    check("settle3_stimulus", stim_err, 0);
    check("settle3_mask", {16'd0, o_mask}, {16'd0, SOP6});
    check_beats("settle3", SOP6);
    tick();
    sel = 1'b0;

    // reset while scanning idx 7
    set_start(1'b1);
    tick();
    set_start(1'b0);
    for (int i = 0; i < 7; i++) tick();
    check("midscan_idx", {28'd0, o_idx}, 32'd7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("midscan_reset");
    run(0, 0, 0);
    check("after_reset_mask", {16'd0, o_mask}, {16'd0, SOP6});
    check_beats("after_reset", SOP6);
    tick();

    // start pulse in the middle of EMIT
    run(0, 0, 20);
    check("emit_start_done_at", done_at, 33);
    check_beats("emit_start", SOP6);
    tick();
    check("emit_start_idle", {31'd0, o_busy}, 32'd0);

    // reference mismatch, then cleared by the next start
    fn_mask = SOP5;
    run(0, 0, 0);
    check("sop5_mask", {16'd0, o_mask}, {16'd0, SOP5});
    check("sop5_count", {27'd0, o_count}, 32'd5);
    tick();
    check("sop5_mismatch", {31'd0, o_mm}, {31'd0, MM_SOP5});
    set_start(1'b1);
    tick();
    set_start(1'b0);
    check("sop5_mismatch_clear", {31'd0, o_mm}, 32'd0);
    check("restart_busy", {31'd0, o_busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/minterm_scanner.md
Name: minterm_scanner

Overview:
- Sequential truth-table reader for a 4-input combinational function (x, y, w, z -> s), the counterpart of the sum-of-products evaluators.
- Drives all 16 input combinations onto the function under test, samples its output, and builds a 16-bit minterm mask, for example SoP(1,2,3,5,7,11) = 16'h08AE.
- Emits the index of each set minterm in ascending order over a valid/ready stream, then pulses done.
- Sits beside the SoP blocks as a self-checking harness and minterm extractor.

Parameters:
- SETTLE, default 0: extra wait cycles per combination before s_in is sampled (0..15).
- EXPECTED, default 16'h08AE: reference mask, used only when MINTERM_CHECK_EN is defined.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: begin a scan; sampled only in IDLE.
- x, y, w, z, output, 1 each: stimulus to the function under test; idx = {x,y,w,z}, x is the MSB.
- s_in, input, 1: output of the function under test; combinational from x, y, w, z.
- busy, output, 1: high in SCAN and EMIT.
- done, output, 1: one-cycle pulse when the stream has finished.
- mask, output, 16: bit i = sampled s_in for idx i.
- count, output, 5: number of set bits in mask (0..16).
- m_valid, output, 1: minterm stream valid.
- m_index, output, 4: minterm index.
- m_ready, input, 1: stream consumer ready.
- mismatch, output, 1: mask differs from EXPECTED (see Optional Feature).

Behaviour:
- Reset values: state=IDLE; x=y=w=z=0; mask=0; count=0; busy=0; done=0; m_valid=0; m_index=0; mismatch=0. Reset overrides every other input and aborts a scan or emit in progress.
- IDLE:
  - start=1 -> SCAN. In the same edge: idx=0, mask=0, count=0, settle counter=0, mismatch=0.
  - mask and count from the previous run hold until that edge.
- SCAN:
  - idx is held for SETTLE+1 cycles.
  - On the last of those cycles: mask[idx] <= s_in, count increments if s_in=1, and idx advances.
  - After idx=15 is sampled: idx returns to 0 and the FSM -> EMIT.
  - SCAN lasts exactly 16*(SETTLE+1) cycles. With SETTLE=0 there is one sample per cycle.
- EMIT:
  - An internal pointer p walks from 0 to 15. Cells with mask[p]=0 are skipped one per cycle with m_valid=0.
  - When mask[p]=1: m_valid=1 and m_index=p.
  - A beat transfers on a clock edge with m_valid & m_ready. The pointer then advances.
  - While m_ready=0, m_valid and m_index hold stable. m_valid never drops without a transfer.
  - After p=15 is processed -> DONE.
  - mask=0: no beats; EMIT takes 16 cycles.
  - mask=16'hFFFF: 16 beats; count=16.
- DONE: done=1 for exactly one cycle, busy=0, then -> IDLE.
- start while busy or in DONE: ignored, with no effect on state or outputs.
- start held high continuously: a new scan begins on the first IDLE cycle after DONE.
- Stimulus: x, y, w, z reflect idx only in SCAN. They are 0 in all other states.
- s_in=X during a sample: stored as-is. The bench must not rely on X-propagation behaviour.

Optional Feature:
- Macro: MINTERM_CHECK_EN.
- When defined:
  - On the DONE cycle, mismatch <= (mask != EXPECTED).
  - mismatch holds until the next start or reset.
- When undefined: mismatch is tied to 0, and no comparator or register is built.

Test Plan:
- Function = SoP(1,2,3,5,7,11), SETTLE=0, m_ready=1, start pulse -> busy for 16 SCAN cycles plus EMIT; mask=16'h08AE; count=6; beats 1,2,3,5,7,11 in order; done pulses once; with MINTERM_CHECK_EN, mismatch=0.
- Function = constant 0 -> mask=0, count=0, m_valid never asserted, done 33 cycles after start (16 SCAN + 16 EMIT + 1 DONE). Constant 1 -> mask=16'hFFFF, count=16, beats 0..15.
- SoP function with m_ready toggling 1,0,0,1,... -> each beat holds m_index stable while stalled; still exactly 6 beats 1,2,3,5,7,11; no duplicates or drops.
- SETTLE=3 -> each idx held 4 cycles; mask=16'h08AE after 64 SCAN cycles.
- reset asserted at SCAN idx=7, then start again -> all outputs at reset values the next cycle; the new run yields the correct mask. A start pulse mid-EMIT -> ignored, beat sequence unchanged.
- MINTERM_CHECK_EN with function = SoP(1,2,3,5,7) (mask 16'h00AE) -> mismatch=1 after DONE; cleared to 0 on the next start.
